io_port_bank: RTL and testbench

// - Clocked, parametrised I/O port bank for the MC14500B system: one flat 1-bit

---
 rtl/io_port_bank.sv | 146 ++++++++++++++
 tb/tb_io_port_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_port_bank
// Purpose  : Clocked I/O port bank for the MC14500B system. It presents one
//            flat 1-bit address space. Output latches occupy the low
//            addresses and input pins sit directly above them. Addresses
//            above the inputs are unmapped and read as 0. Output latches can
//            be read back. Each input passes through a two-flop synchroniser
//            and an optional per-pin debounce filter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            system clock, all state on rising edge
//   reset        in   1            asynchronous, active-high reset
//   write        in   1            write enable, sampled at rising clk
//   data_in      in   1            bit to write
//   address      in   ADDR_WIDTH   bit address for read and write
//   data_out     out  1            read data for address (combinational)
//   input_pins   in   INPUT_SIZE   raw asynchronous board inputs
//   output_pins  out  OUTPUT_SIZE  output latches, registered
// ============================================================================
module io_port_bank #(
  parameter int                     ADDR_WIDTH      = 4,
  parameter int                     INPUT_SIZE      = 8,
  parameter int                     OUTPUT_SIZE     = 8,
  parameter int                     DEBOUNCE_CYCLES = 3,
  parameter logic [OUTPUT_SIZE-1:0] OUT_RESET       = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic                   data_in,
  input  logic [ADDR_WIDTH-1:0]  address,
  output logic                   data_out,
  input  logic [INPUT_SIZE-1:0]  input_pins,
  output logic [OUTPUT_SIZE-1:0] output_pins
);

  // The address is widened by one bit so that address bounds up to
  // 2**ADDR_WIDTH can be compared without wrapping.
  localparam int c_AXW = ADDR_WIDTH + 1;

  logic [c_AXW-1:0]       w_addr_ext;
  logic [OUTPUT_SIZE-1:0] r_out;
  logic [INPUT_SIZE-1:0]  r_sync1;
  logic [INPUT_SIZE-1:0]  r_sync2;
  logic [INPUT_SIZE-1:0]  w_deb;
  logic                   w_rd_data;

  assign w_addr_ext  = {1'b0, address};
  assign output_pins = r_out;

  // --------------------------------------------------------------------------
  // Output latches: one flop per bit. Each flop is written only when the
  // address decodes to that bit. Input and unmapped addresses never match,
  // so writes to them have no effect.
  // --------------------------------------------------------------------------
  generate
    for (genvar n = 0; n < OUTPUT_SIZE; n++) begin : g_latch
      localparam logic [c_AXW-1:0] c_MY_ADDR = c_AXW'(n);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_out[n] <= OUT_RESET[n];
        end else if (write && (w_addr_ext == c_MY_ADDR)) begin
          r_out[n] <= data_in;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the raw board inputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= input_pins;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce. A synchronised level must differ from the accepted value for
  // DEBOUNCE_CYCLES consecutive edges before it is taken. On the edge where
  // the counter reaches DEBOUNCE_CYCLES-1, the new value is accepted and the
  // counter clears. So the counter never holds DEBOUNCE_CYCLES.
  // --------------------------------------------------------------------------
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_deb = r_sync2;
    end else begin : g_debounce
      localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

      for (genvar k = 0; k < INPUT_SIZE; k++) begin : g_pin
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_stable;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
          end else if (r_sync2[k] == r_stable) begin
            // Level agrees with the accepted value. Any partial
            // qualification is discarded.
            r_cnt <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_stable <= r_sync2[k];
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        assign w_deb[k] = r_stable;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read mux. Every mapped address is compared directly with the widened
  // address. Unmapped addresses fall through to the 0 default. A write in the
  // same cycle is not visible here until the next edge, so a read in that
  // cycle returns the old latch value.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_data = 1'b0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      if (w_addr_ext == c_AXW'(i)) begin
        w_rd_data = r_out[i];
      end
    end
    for (int j = 0; j < INPUT_SIZE; j++) begin
      if (w_addr_ext == c_AXW'(OUTPUT_SIZE + j)) begin
        w_rd_data = w_deb[j];
      end
    end
  end

  assign data_out = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_bank
// Purpose  : Directed bench for io_port_bank. It uses three builds:
//              dut  - ADDR_WIDTH 4, debounce 3
//              dut5 - ADDR_WIDTH 5, so addresses 16..31 are unmapped
//              dut0 - debounce bypassed
//            All three builds reset the outputs to 8'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic       data_in;
  logic [3:0] address;
  logic [4:0] addr5;
  logic [7:0] input_pins;

  logic       data_out;
  logic       data_out5;
  logic       data_out0;
  logic [7:0] output_pins;
  logic [7:0] output_pins5;
  logic [7:0] output_pins0;

  int checks = 0;
  int errors = 0;

  io_port_bank #(
    .ADDR_WIDTH(4), .INPUT_SIZE(8), .OUTPUT_SIZE(8),
    .DEBOUNCE_CYCLES(3), .OUT_RESET(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in),
    .address(address), .data_out(data_out),
    .input_pins(input_pins), .output_pins(output_pins)
  );

  io_port_bank #(
    .ADDR_WIDTH(5), .INPUT_SIZE(8), .OUTPUT_SIZE(8),
    .DEBOUNCE_CYCLES(3), .OUT_RESET(8'hA5)
  ) dut5 (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in),
    .address(addr5), .data_out(data_out5),
    .input_pins(input_pins), .output_pins(output_pins5)
  );

  io_port_bank #(
    .ADDR_WIDTH(4), .INPUT_SIZE(8), .OUTPUT_SIZE(8),
    .DEBOUNCE_CYCLES(0), .OUT_RESET(8'hA5)
  ) dut0 (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in),
    .address(address), .data_out(data_out0),
    .input_pins(input_pins), .output_pins(output_pins0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rst_val;
    rst_val    = 8'hA5;
    reset      = 1'b1;
    write      = 1'b0;
    data_in    = 1'b0;
    address    = 4'd0;
    addr5      = 5'd20;
    input_pins = 8'h00;

    // ---------------- reset state ----------------
    step();
    step();
    chk("out_in_reset", output_pins, 8'hA5);
    reset = 1'b0;
    #1;
    chk("out_after_reset", output_pins, 8'hA5);
    chk("out5_after_reset", output_pins5, 8'hA5);
    for (int a = 0; a < 16; a++) begin
      address = a[3:0];
      #1;
      chk($sformatf("rst_read_%0d", a), data_out, (a < 8) ? rst_val[a] : 1'b0);
    end
    chk("rd5_unmapped_20", data_out5, 0);

    // ---------------- write address 3 ----------------
    step();
    address = 4'd3;
    write   = 1'b1;
    data_in = 1'b1;
    #1;
    chk("wr3_same_cycle_old", data_out, 0);
    step();
    write   = 1'b0;
    data_in = 1'b0;
    #1;
    chk("wr3_out_pins", output_pins, 8'hAD);
    chk("wr3_readback", data_out, 1);

    // ---------------- writes to input / unmapped addresses ----------------
    address = 4'd9;
    write   = 1'b1;
    data_in = 1'b1;
    addr5   = 5'd20;
    step();
    write   = 1'b0;
    data_in = 1'b0;
    #1;
    chk("wr_input_addr_ignored", output_pins, 8'hAD);
    chk("rd_input_addr_9", data_out, 0);
    chk("wr_unmapped_ignored", output_pins5, 8'hA5);
    chk("rd_unmapped_20", data_out5, 0);

    // ---------------- held input rise, D=3 and D=0 ----------------
    address       = 4'd10;
    input_pins[2] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("rise_d3_edge%0d", e), data_out, (e == 5) ? 1 : 0);
      chk($sformatf("rise_d0_edge%0d", e), data_out0, (e >= 2) ? 1 : 0);
    end
    input_pins[2] = 1'b0;
    repeat (7) step();
    chk("fall_d3_settled", data_out, 0);
    chk("fall_d0_settled", data_out0, 0);

    // ---------------- 1-cycle pulse ----------------
    input_pins[2] = 1'b1;
    step();
    input_pins[2] = 1'b0;
    chk("pulse1_d0_edge1", data_out0, 0);
    chk("pulse1_d3_edge1", data_out, 0);
    for (int e = 2; e <= 7; e++) begin
      step();
      chk($sformatf("pulse1_d3_edge%0d", e), data_out, 0);
      chk($sformatf("pulse1_d0_edge%0d", e), data_out0, (e == 2) ? 1 : 0);
    end

    // ---------------- 2-cycle pulse ----------------
    input_pins[2] = 1'b1;
    step();
    step();
    input_pins[2] = 1'b0;
    for (int e = 3; e <= 8; e++) begin
      step();
      chk($sformatf("pulse2_d3_edge%0d", e), data_out, 0);
    end

    // ---------------- reset mid-debounce with all outputs set ----------------
    for (int i = 0; i < 8; i++) begin
      address = i[3:0];
      write   = 1'b1;
      data_in = 1'b1;
      step();
    end
    write   = 1'b0;
    data_in = 1'b0;
    #1;
    chk("all_ones_out", output_pins, 8'hFF);
    address       = 4'd10;
    input_pins[2] = 1'b1;
    repeat (4) step();
    chk("mid_debounce_still_0", data_out, 0);
    reset = 1'b1;
    #1;
    chk("async_reset_out", output_pins, 8'hA5);
    chk("async_reset_read10", data_out, 0);
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("requal_edge%0d", e), data_out, (e == 5) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
